// File: rtl/net_resolver_pkg.sv
// rtl/net_resolver_pkg.sv - shared encodings for the wired-net resolver
// Purpose: net-kind and float-behaviour selectors, plus the 2-bit bus_state encoding.
// Ports: none (package).
package net_resolver_pkg;

   // Net kind (MODE parameter)
   localparam int MODE_TRI  = 0;
   localparam int MODE_WOR  = 1;
   localparam int MODE_WAND = 2;

   // Float behaviour (PULL parameter)
   localparam int PULL_KEEP = 0;
   localparam int PULL_0    = 1;
   localparam int PULL_1    = 2;

   typedef enum logic [1:0] {
      ST_FLOAT      = 2'b00,
      ST_DRIVEN     = 2'b01,
      ST_CONTENTION = 2'b10,
      ST_DECAYED    = 2'b11
   } bus_state_e;

endpackage

// File: rtl/net_resolver_if.sv
// rtl/net_resolver_if.sv - driver/observer bundle for the wired-net resolver
// Purpose: groups the channel drives, contention clear and resolved-net outputs.
// Ports (signals):
//   drv_en[N], drv_data[N*W], clr_contention  -> driven by master
//   bus_q[W], bus_state[2], contention, contention_cnt[CNT_W] -> driven by slave
interface net_resolver_if #(
   parameter int N     = 4,
   parameter int W     = 8,
   parameter int CNT_W = 8
);
   logic [N-1:0]     drv_en;
   logic [N*W-1:0]   drv_data;
   logic             clr_contention;
   logic [W-1:0]     bus_q;
   logic [1:0]       bus_state;
   logic             contention;
   logic [CNT_W-1:0] contention_cnt;

   modport master (
      output drv_en, drv_data, clr_contention,
      input  bus_q, bus_state, contention, contention_cnt
   );

   modport slave (
      input  drv_en, drv_data, clr_contention,
      output bus_q, bus_state, contention, contention_cnt
   );
endinterface

// File: rtl/net_resolve_comb.sv
// rtl/net_resolve_comb.sv - combinational resolution of N enabled drivers
// Purpose: computes the resolved net value for the configured net kind and flags
//          tri-state conflicts.
// Ports:
//   drv_en_i    in  N    per-channel enable
//   drv_data_i  in  N*W  channel i at [i*W +: W]
//   value_o     out W    resolved value (meaningful only when any_en_o)
//   any_en_o    out 1    at least one channel enabled
//   conflict_o  out 1    TRI only: enabled drivers disagree on some bit
module net_resolve_comb
   import net_resolver_pkg::*;
#(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int MODE = MODE_TRI
) (
   input  logic [N-1:0]   drv_en_i,
   input  logic [N*W-1:0] drv_data_i,
   output logic [W-1:0]   value_o,
   output logic           any_en_o,
   output logic           conflict_o
);

   logic [W-1:0] and_v;
   logic [W-1:0] or_v;

   // AND/OR over enabled channels only. A bit is agreed exactly where and_v==or_v;
   // on disagreeing bits and_v is 0, so and_v is also the TRI resolution with 0
   // standing in for X.
   always_comb begin
      and_v = '1;
      or_v  = '0;
      for (int i = 0; i < N; i++) begin
         if (drv_en_i[i]) begin
            and_v = and_v & drv_data_i[i*W +: W];
            or_v  = or_v  | drv_data_i[i*W +: W];
         end
      end
   end

   always_comb begin
      any_en_o   = |drv_en_i;
      value_o    = (MODE == MODE_WOR) ? or_v : and_v;
      conflict_o = (MODE == MODE_TRI) && any_en_o && (and_v != or_v);
   end

endmodule

// File: rtl/net_resolver.sv
// rtl/net_resolver.sv - registered multi-driver wired-net model with contention tracking
// Purpose: resolves N channel drives per MODE, applies PULL float behaviour,
//          registers the result and keeps a sticky contention flag and saturating
//          contention counter. Optional keeper decay under NET_RESOLVER_DECAY_EN.
// Ports:
//   clk    in  1  clock, rising edge
//   rst_n  in  1  asynchronous active-low reset
//   bus    net_resolver_if.slave: drv_en, drv_data, clr_contention in;
//          bus_q, bus_state, contention, contention_cnt out
// Configuration macro: NET_RESOLVER_DECAY_EN
module net_resolver
   import net_resolver_pkg::*;
#(
   parameter int N         = 4,
   parameter int W         = 8,
   parameter int MODE      = MODE_TRI,
   parameter int PULL      = PULL_KEEP,
   parameter int CNT_W     = 8,
   parameter int DECAY_CYC = 16
) (
   input logic           clk,
   input logic           rst_n,
   net_resolver_if.slave bus
);

`ifdef NET_RESOLVER_DECAY_EN
   localparam bit DECAY_EN = 1'b1;
`else
   localparam bit DECAY_EN = 1'b0;
`endif

   localparam logic [W-1:0]     RST_VAL    = (PULL == PULL_1) ? '1 : '0;
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam int               DCW        = (DECAY_CYC > 1) ? $clog2(DECAY_CYC + 1) : 1;
   localparam logic [DCW-1:0]   DECAY_LAST = DCW'((DECAY_CYC > 0) ? DECAY_CYC - 1 : 0);

   logic [W-1:0]     res_val;
   logic             any_en;
   logic             conflict;

   logic [W-1:0]     bus_val_q,   bus_val_d;
   bus_state_e       state_q,     state_d;
   logic             flag_q,      flag_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [DCW-1:0]   decay_cnt_q, decay_cnt_d;

   net_resolve_comb #(
      .N    (N),
      .W    (W),
      .MODE (MODE)
   ) u_comb (
      .drv_en_i   (bus.drv_en),
      .drv_data_i (bus.drv_data),
      .value_o    (res_val),
      .any_en_o   (any_en),
      .conflict_o (conflict)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_val_q   <= RST_VAL;
         state_q     <= ST_FLOAT;
         flag_q      <= 1'b0;
         cnt_q       <= '0;
         decay_cnt_q <= '0;
      end else begin
         bus_val_q   <= bus_val_d;
         state_q     <= state_d;
         flag_q      <= flag_d;
         cnt_q       <= cnt_d;
         decay_cnt_q <= decay_cnt_d;
      end
   end

   always_comb begin
      bus_val_d   = bus_val_q;   // keeper: bus_q register doubles as the held value
      state_d     = ST_FLOAT;
      flag_d      = flag_q;
      cnt_d       = cnt_q;
      decay_cnt_d = '0;          // any driven cycle restarts the float run

      if (any_en) begin
         bus_val_d = res_val;
         state_d   = conflict ? ST_CONTENTION : ST_DRIVEN;
      end else if (PULL == PULL_0) begin
         bus_val_d = '0;
      end else if (PULL == PULL_1) begin
         bus_val_d = '1;
      end else if (DECAY_EN) begin
         // DECAYED is sticky until a driver returns; otherwise count float cycles
         // and decay on the DECAY_CYC-th one.
         if (state_q == ST_DECAYED || decay_cnt_q == DECAY_LAST) begin
            state_d   = ST_DECAYED;
            bus_val_d = '0;
         end else begin
            decay_cnt_d = decay_cnt_q + 1'b1;
         end
      end

      // Set beats clear: a clear in a contention cycle restarts the count at 1.
      if (conflict) begin
         flag_d = 1'b1;
         if (bus.clr_contention) begin
            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
         end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (bus.clr_contention) begin
         flag_d = 1'b0;
         cnt_d  = '0;
      end
   end

   assign bus.bus_q          = bus_val_q;
   assign bus.bus_state      = state_q;
   assign bus.contention     = flag_q;
   assign bus.contention_cnt = cnt_q;

endmodule
